counter_bank: RTL and testbench

- Multi-channel successor to the single-shot down-counter.
- NUM_CH independent down-counters, each loaded with a per-request amount and optionally auto-reloading (periodic mode).
- Per-channel busy level and single-cycle done pulse; per-channel abort.
- Sits beside control FSMs as a shared timer/delay resource; start uses the ENA/RDY method handshake.

---
 rtl/counter_bank.sv | 80 ++++++++
 tb/tb_counter_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of independent down-counters with one-shot/periodic modes
// Start uses ENA/RDY; abort is always accepted and overrides a same-cycle start.
module counter_bank #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_AMOUNT = 22,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start__ENA,
  output logic              start__RDY,
  input  logic [CH_W-1:0]   start_ch,
  input  logic [WIDTH-1:0]  start_amount,
  input  logic              start_periodic,
  input  logic              abort__ENA,
  input  logic [CH_W-1:0]   abort_ch,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam logic [WIDTH-1:0] MaxLoad = WIDTH'(MAX_AMOUNT);

  logic [WIDTH-1:0] loadVal;
  logic             startFire;

  // Zero and out-of-range amounts both saturate to the ceiling.
  assign loadVal   = (start_amount == '0 || start_amount > MaxLoad) ? MaxLoad : start_amount;
  assign startFire = start__ENA & start__RDY;

  // Channels that do not exist never match, so their RDY stays low.
  always_comb begin
    start__RDY = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (start_ch == CH_W'(i)) start__RDY = ~busy[i];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] reload;
    logic             per;
    logic             doneQ;
    logic             startHit;
    logic             abortHit;

    assign startHit = startFire & (start_ch == CH_W'(i));
    assign abortHit = abort__ENA & (abort_ch == CH_W'(i));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt    <= '0;
        reload <= '0;
        per    <= 1'b0;
        doneQ  <= 1'b0;
      end else begin
        doneQ <= 1'b0;
        if (abortHit) begin
          cnt <= '0;
          per <= 1'b0;
        end else if (startHit) begin
          cnt    <= loadVal;
          reload <= loadVal;
          per    <= start_periodic;
        end else if (cnt != '0) begin
          if (cnt == WIDTH'(1)) begin
            doneQ <= 1'b1;
            cnt   <= per ? reload : '0;
          end else begin
            cnt <= cnt - WIDTH'(1);
          end
        end
      end
    end

    assign busy[i] = (cnt != '0);
    assign done[i] = doneQ;
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - directed vector bench for counter_bank
module tb_counter_bank;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start__ENA;
  logic       start__RDY;
  logic [1:0] start_ch;
  logic [7:0] start_amount;
  logic       start_periodic;
  logic       abort__ENA;
  logic [1:0] abort_ch;
  logic [3:0] busy;
  logic [3:0] done;

  int checks = 0;
  int failures = 0;

  counter_bank dut (
    .CLK(CLK), .RST(RST),
    .start__ENA(start__ENA), .start__RDY(start__RDY), .start_ch(start_ch),
    .start_amount(start_amount), .start_periodic(start_periodic),
    .abort__ENA(abort__ENA), .abort_ch(abort_ch),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       sEna;
    logic [1:0] sCh;
    logic [7:0] sAmt;
    logic       sPer;
    logic       aEna;
    logic [1:0] aCh;
    logic [3:0] eBusy;
    logic [3:0] eDone;
    logic       eRdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic se, logic [1:0] sc, logic [7:0] sa, logic sp,
                              logic ae, logic [1:0] ac, logic [3:0] eb, logic [3:0] ed, logic er);
    vec_t v;
    v.sEna = se; v.sCh = sc; v.sAmt = sa; v.sPer = sp;
    v.aEna = ae; v.aCh = ac; v.eBusy = eb; v.eDone = ed; v.eRdy = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic se, input logic [1:0] sc, input logic [7:0] sa,
                       input logic sp, input logic ae, input logic [1:0] ac);
    start__ENA = se; start_ch = sc; start_amount = sa; start_periodic = sp;
    abort__ENA = ae; abort_ch = ac;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", 8'(busy), 8'h0);
    chk("reset_done", 8'(done), 8'h0);
    chk("reset_rdy", 8'(start__RDY), 8'h1);
    RST = 1'b0;
    nextCycle();

    // one-shot ch0 amount 5
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 4'b0000, 4'b0000, 1));
    for (int c = 0; c < 5; c++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    // periodic ch3 amount 3, abort in cycle 10
    tbl.push_back(mk(1, 3, 3, 1, 0, 0, 4'b0000, 4'b0000, 1));
    for (int c = 0; c < 10; c++)
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 4'b1000, (c > 0 && c % 3 == 0) ? 4'b1000 : 4'b0000, 0));
    tbl.push_back(mk(0, 3, 0, 0, 1, 3, 4'b1000, 4'b0000, 0));
    for (int c = 11; c < 14; c++) tbl.push_back(mk(0, 3, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    // abort ch0 while cnt==1
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    // start+abort same channel: abort wins
    tbl.push_back(mk(1, 2, 5, 0, 1, 2, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    // start ch1 with abort on another (idle) channel
    tbl.push_back(mk(1, 1, 2, 0, 1, 2, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0000, 4'b0010, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    // all channels amount 4 on consecutive cycles, ch0 restarted in its done cycle
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(1, 1, 4, 0, 0, 0, 4'b0001, 4'b0000, 1));
    tbl.push_back(mk(1, 2, 4, 0, 0, 0, 4'b0011, 4'b0000, 1));
    tbl.push_back(mk(1, 3, 4, 0, 0, 0, 4'b0111, 4'b0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 4'b1110, 4'b0001, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b1101, 4'b0010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b1001, 4'b0100, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0001, 4'b1000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].sEna, tbl[i].sCh, tbl[i].sAmt, tbl[i].sPer, tbl[i].aEna, tbl[i].aCh);
      @(negedge CLK);
      chk($sformatf("vec%0d_busy", i), 8'(busy), 8'(tbl[i].eBusy));
      chk($sformatf("vec%0d_done", i), 8'(done), 8'(tbl[i].eDone));
      chk($sformatf("vec%0d_rdy", i), 8'(start__RDY), 8'(tbl[i].eRdy));
      nextCycle();
    end

    // amount 0 on ch1 and amount 200 on ch2 both saturate to 22
    drive(1, 1, 0, 0, 0, 0);
    nextCycle();
    drive(1, 2, 200, 0, 0, 0);
    for (int c = 0; c < 26; c++) begin
      if (c == 1) drive(0, 1, 0, 0, 0, 0);
      @(negedge CLK);
      chk($sformatf("sat_c%0d_busy1", c), 8'(busy[1]), 8'(c <= 21));
      chk($sformatf("sat_c%0d_done1", c), 8'(done[1]), 8'(c == 22));
      chk($sformatf("sat_c%0d_busy2", c), 8'(busy[2]), 8'(c >= 1 && c <= 22));
      chk($sformatf("sat_c%0d_done2", c), 8'(done[2]), 8'(c == 23));
      chk($sformatf("sat_c%0d_rdy", c), 8'(start__RDY), 8'(c == 0 || c >= 22));
      nextCycle();
    end

    // reset asserted mid-count with ch1 at 10
    drive(1, 1, 20, 0, 0, 0);
    nextCycle();
    drive(0, 1, 0, 0, 0, 0);
    repeat (10) nextCycle();
    @(negedge CLK);
    chk("midrst_pre_busy", 8'(busy), 8'h02);
    RST = 1'b1;
    #1;
    chk("midrst_busy", 8'(busy), 8'h0);
    chk("midrst_done", 8'(done), 8'h0);
    chk("midrst_rdy", 8'(start__RDY), 8'h1);
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      chk($sformatf("postrst_c%0d_busy", c), 8'(busy), 8'h0);
      chk($sformatf("postrst_c%0d_done", c), 8'(done), 8'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
